// File: rtl/dpwm_compensator.sv
// Three-tap PID compensator feeding the DPWM duty input.
// One multiplier is time-shared over the taps; the output is clamped, with anti-windup.
module dpwm_compensator #(
  parameter int unsigned N     = 12,
  parameter int unsigned ADC_W = 12,
  parameter int unsigned CW    = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic                 hf_clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ADC_W-1:0]     adc_data,
  input  logic                 adc_valid,
  input  logic [ADC_W-1:0]     vref,
  input  logic signed [CW-1:0] coef_a,
  input  logic signed [CW-1:0] coef_b,
  input  logic signed [CW-1:0] coef_c,
  input  logic [N-1:0]         dmin,
  input  logic [N-1:0]         dmax,
  output logic [N-1:0]         duty_cycle,
  output logic                 duty_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned EW = ADC_W + 1;
  localparam int unsigned PW = CW + EW;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAC0 = 3'd1;
  localparam logic [2:0] S_MAC1 = 3'd2;
  localparam logic [2:0] S_MAC2 = 3'd3;
  localparam logic [2:0] S_SAT  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic signed [EW-1:0]    e0_q, e0_d, e1_q, e1_d, e2_q, e2_d;
  logic signed [ACC_W-1:0] u_q, u_d, acc_q, acc_d;
  logic [N-1:0]            duty_q, duty_d;
  logic                    duty_valid_q, duty_valid_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  logic signed [EW-1:0]    e_new;
  logic signed [CW-1:0]    coef_sel;
  logic signed [EW-1:0]    err_sel;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_base, acc_sum;
  logic signed [ACC_W-1:0] y, lo_val, dmin_s, dmax_s;
  logic [N-1:0]            lo_sel, duty_sel;
  logic                    below, above;

  // Shared MAC datapath: tap select, product, accumulate.
  always_comb begin
    e_new    = $signed({1'b0, vref}) - $signed({1'b0, adc_data});
    coef_sel = coef_a;
    err_sel  = e0_q;
    acc_base = acc_q;
    case (state_q)
      S_MAC0: begin
        coef_sel = coef_a;
        err_sel  = e0_q;
        acc_base = u_q;
      end
      S_MAC1: begin
        coef_sel = coef_b;
        err_sel  = e1_q;
      end
      S_MAC2: begin
        coef_sel = coef_c;
        err_sel  = e2_q;
      end
      default: ;
    endcase
    prod    = PW'(coef_sel) * PW'(err_sel);
    acc_sum = acc_base + ACC_W'(prod);
  end

  // Saturation: the lower clamp is applied first, so dmax wins when dmin > dmax.
  always_comb begin
    y        = acc_q >>> FRAC;
    dmin_s   = $signed(ACC_W'(dmin));
    dmax_s   = $signed(ACC_W'(dmax));
    below    = (y < dmin_s);
    lo_val   = below ? dmin_s : y;
    lo_sel   = below ? dmin : y[N-1:0];
    above    = (lo_val > dmax_s);
    duty_sel = above ? dmax : lo_sel;
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d      = state_q;
    e0_d         = e0_q;
    e1_d         = e1_q;
    e2_d         = e2_q;
    u_d          = u_q;
    acc_d        = acc_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    overrun_d    = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
      e0_d    = '0;
      e1_d    = '0;
      e2_d    = '0;
      u_d     = '0;
      acc_d   = '0;
      duty_d  = dmin;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (adc_valid) begin
            e2_d    = e1_q;
            e1_d    = e0_q;
            e0_d    = e_new;
            state_d = S_MAC0;
          end
        end
        S_MAC0: begin
          acc_d   = acc_sum;
          state_d = S_MAC1;
        end
        S_MAC1: begin
          acc_d   = acc_sum;
          state_d = S_MAC2;
        end
        S_MAC2: begin
          acc_d   = acc_sum;
          state_d = S_SAT;
        end
        S_SAT: begin
          duty_d       = duty_sel;
          duty_valid_d = 1'b1;
          u_d          = (below || above) ? (ACC_W'(duty_sel) << FRAC) : acc_q;
          state_d      = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      overrun_d = adc_valid && (state_q != S_IDLE);
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge hf_clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      e0_q         <= '0;
      e1_q         <= '0;
      e2_q         <= '0;
      u_q          <= '0;
      acc_q        <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      e0_q         <= e0_d;
      e1_q         <= e1_d;
      e2_q         <= e2_d;
      u_q          <= u_d;
      acc_q        <= acc_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign duty_cycle = duty_q;
  assign duty_valid = duty_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_dpwm_compensator.sv
// Directed bench for dpwm_compensator: reset, integration, clamping, overrun and abort.
module tb_dpwm_compensator;

  logic               hf_clock = 1'b0;
  logic               reset;
  logic               enable;
  logic [11:0]        adc_data;
  logic               adc_valid;
  logic [11:0]        vref;
  logic signed [15:0] coef_a, coef_b, coef_c;
  logic [11:0]        dmin, dmax;
  logic [11:0]        duty_cycle;
  logic               duty_valid, busy, overrun;

  int checks   = 0;
  int failures = 0;

  dpwm_compensator dut (
    .hf_clock  (hf_clock),
    .reset     (reset),
    .enable    (enable),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .vref      (vref),
    .coef_a    (coef_a),
    .coef_b    (coef_b),
    .coef_c    (coef_c),
    .dmin      (dmin),
    .dmax      (dmax),
    .duty_cycle(duty_cycle),
    .duty_valid(duty_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 hf_clock = ~hf_clock;

  // Present one sample and count edges until duty_valid (0 = never within 10 edges).
  task automatic sample_and_wait(input logic [11:0] adc, output int lat);
    @(negedge hf_clock);
    adc_data  = adc;
    adc_valid = 1'b1;
    @(posedge hf_clock);
    #1 adc_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge hf_clock);
      #1;
      if (duty_valid) lat = i;
    end
  endtask

  // Clear compensator state through a one-cycle enable drop.
  task automatic clear_state();
    @(negedge hf_clock);
    enable = 1'b0;
    @(negedge hf_clock);
    enable = 1'b1;
  endtask

  task automatic test_reset();
    int lat;
    int pulses;
    checks++;
    if (duty_cycle !== 12'd0 || duty_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_state duty=%0d dv=%b busy=%b ovr=%b expected all 0",
               duty_cycle, duty_valid, busy, overrun);
    end
    coef_a = 16'sd256; coef_b = 16'sd0; coef_c = 16'sd0;
    vref = 12'd2048; dmin = 12'd0; dmax = 12'd4095;
    @(negedge hf_clock);
    reset = 1'b1;
    sample_and_wait(12'd2038, lat);
    checks++;
    if (duty_cycle !== 12'd10) begin
      failures++;
      $display("FAIL reset_pre_duty got=%0d expected=10", duty_cycle);
    end
    // Second sample, reset asserted mid-cycle while in MAC1.
    @(negedge hf_clock);
    adc_valid = 1'b1;
    @(posedge hf_clock);
    #1 adc_valid = 1'b0;
    @(posedge hf_clock);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy_before got=%b expected=1", busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (duty_cycle !== 12'd0 || duty_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_async duty=%0d dv=%b busy=%b ovr=%b expected all 0",
               duty_cycle, duty_valid, busy, overrun);
    end
    @(negedge hf_clock);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge hf_clock);
      #1;
      if (duty_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL reset_no_pulse got=%0d pulses expected=0", pulses);
    end
  endtask

  task automatic test_integrator();
    int lat;
    int exp_duty [3] = '{10, 20, 30};
    coef_a = 16'sd256; coef_b = 16'sd0; coef_c = 16'sd0;
    vref = 12'd2048; dmin = 12'd0; dmax = 12'd4095;
    for (int k = 0; k < 3; k++) begin
      sample_and_wait(12'd2038, lat);
      checks++;
      if (lat !== 4 || duty_cycle !== 12'(exp_duty[k])) begin
        failures++;
        $display("FAIL integrator_%0d lat=%0d duty=%0d expected lat=4 duty=%0d",
                 k, lat, duty_cycle, exp_duty[k]);
      end
    end
  endtask

  task automatic test_anti_windup();
    int lat;
    clear_state();
    coef_a = 16'sd256; coef_b = 16'sd0; coef_c = 16'sd0;
    vref = 12'd4000; dmin = 12'd0; dmax = 12'd3000;
    sample_and_wait(12'd0, lat);
    checks++;
    if (lat !== 4 || duty_cycle !== 12'd3000) begin
      failures++;
      $display("FAIL windup_clamp lat=%0d duty=%0d expected lat=4 duty=3000", lat, duty_cycle);
    end
    repeat (3) @(posedge hf_clock);
    #1;
    checks++;
    if (duty_cycle !== 12'd3000) begin
      failures++;
      $display("FAIL windup_hold got=%0d expected=3000", duty_cycle);
    end
    sample_and_wait(12'd4010, lat);
    checks++;
    if (lat !== 4 || duty_cycle !== 12'd2990) begin
      failures++;
      $display("FAIL windup_recover lat=%0d duty=%0d expected lat=4 duty=2990", lat, duty_cycle);
    end
  endtask

  task automatic test_lower_clamp();
    int lat;
    dmin = 12'd0;
    clear_state();
    coef_a = 16'sd256; coef_b = 16'sd0; coef_c = 16'sd0;
    vref = 12'd1000; dmin = 12'd100; dmax = 12'd4095;
    sample_and_wait(12'd1500, lat);
    checks++;
    if (lat !== 4 || duty_cycle !== 12'd100) begin
      failures++;
      $display("FAIL lower_clamp lat=%0d duty=%0d expected lat=4 duty=100", lat, duty_cycle);
    end
  endtask

  task automatic test_overrun();
    int lat;
    int pulses;
    int ovr_pulses;
    dmin = 12'd0;
    clear_state();
    coef_a = 16'sd256; coef_b = 16'sd256; coef_c = 16'sd0;
    vref = 12'd2048; dmax = 12'd4095;
    @(negedge hf_clock);
    adc_data = 12'd2038; adc_valid = 1'b1;
    @(posedge hf_clock);
    #1;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_first got=%b expected=0", overrun);
    end
    @(negedge hf_clock);
    adc_data = 12'd2000;
    @(posedge hf_clock);
    #1;
    adc_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_pulse got=%b expected=1", overrun);
    end
    pulses = 0; ovr_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge hf_clock);
      #1;
      if (duty_valid) pulses++;
      if (overrun) ovr_pulses++;
    end
    checks++;
    if (pulses !== 1 || ovr_pulses !== 0 || duty_cycle !== 12'd10) begin
      failures++;
      $display("FAIL overrun_single pulses=%0d ovr=%0d duty=%0d expected 1 0 10",
               pulses, ovr_pulses, duty_cycle);
    end
    // u=2560, e0=e1=10: 2560 + 256*10 + 256*10 = 7680 -> 30 only if history was kept.
    sample_and_wait(12'd2038, lat);
    checks++;
    if (lat !== 4 || duty_cycle !== 12'd30) begin
      failures++;
      $display("FAIL overrun_history lat=%0d duty=%0d expected lat=4 duty=30", lat, duty_cycle);
    end
  endtask

  task automatic test_abort();
    int lat;
    int pulses;
    dmin = 12'd0;
    clear_state();
    coef_a = 16'sd256; coef_b = 16'sd0; coef_c = 16'sd0;
    vref = 12'd2048; dmax = 12'd4095; dmin = 12'd50;
    @(negedge hf_clock);
    adc_data = 12'd2038; adc_valid = 1'b1;
    @(posedge hf_clock);
    #1 adc_valid = 1'b0;
    repeat (2) @(posedge hf_clock);
    @(negedge hf_clock);
    enable = 1'b0;
    pulses = 0;
    @(posedge hf_clock);
    #1;
    if (duty_valid) pulses++;
    @(negedge hf_clock);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge hf_clock);
      #1;
      if (duty_valid) pulses++;
    end
    checks++;
    if (pulses !== 0 || duty_cycle !== 12'd50 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort pulses=%0d duty=%0d busy=%b expected 0 50 0", pulses, duty_cycle, busy);
    end
    dmin = 12'd0;
    sample_and_wait(12'd2038, lat);
    checks++;
    if (lat !== 4 || duty_cycle !== 12'd10) begin
      failures++;
      $display("FAIL abort_restart lat=%0d duty=%0d expected lat=4 duty=10", lat, duty_cycle);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    clear_state();
    coef_a = 16'sd256; coef_b = 16'sd0; coef_c = 16'sd0;
    vref = 12'd2048; dmin = 12'd0; dmax = 12'd4095;
    sample_and_wait(12'd2038, lat);
    // Next sample accepted at the first edge after SAT: 5-cycle throughput.
    sample_and_wait(12'd2048, lat);
    checks++;
    if (lat !== 4 || duty_cycle !== 12'd10 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back lat=%0d duty=%0d ovr=%b expected 4 10 0", lat, duty_cycle, overrun);
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; adc_valid = 1'b0; adc_data = '0; vref = '0;
    coef_a = '0; coef_b = '0; coef_c = '0; dmin = '0; dmax = '0;
    #22;
    test_reset();
    test_integrator();
    test_anti_windup();
    test_lower_clamp();
    test_overrun();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
